call_stack: RTL
===============

// Module: call_stack
// PURPOSE
//  Parametrised return-address/data stack for the multicycle core. Generalises the fixed call/return
//  stack: configurable width and depth, a circular mode that drops the oldest entry on full,
//  push+pop replace, indexed peek, flush, and sticky overflow/underflow flags for the control unit.
//  Single clock domain. The processor drives push/pop from its control FSM and feeds top to its PC mux.
// PARAMETERS
//  DATA_W        32  entry width in bits
//  DEPTH         16  number of entries; any value >= 2, need not be a power of two
//  WRAP_ON_FULL  0   0: push when full is rejected; 1: push when full overwrites the oldest entry
//  AW            $clog2(DEPTH)    index width (derived, localparam)
//  CW            $clog2(DEPTH+1)  count width (derived, localparam)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous reset, active-high
//  push       in   1       write push_data on top this cycle
//  pop        in   1       remove top entry this cycle
//  push_data  in   DATA_W  value to push (e.g. PC or ALU result)
//  flush      in   1       synchronous empty; priority over push/pop
//  clear_err  in   1       synchronous clear of overflow/underflow
//  peek_idx   in   AW      depth below top to read; 0 = top
//  top        out  DATA_W  current top entry; 0 when empty
//  peek_data  out  DATA_W  entry at peek_idx; 0 when peek_idx >= count
//  count      out  CW      number of valid entries, 0..DEPTH
//  empty      out  1       count == 0
//  full       out  1       count == DEPTH
//  overflow   out  1       sticky: push attempted while full (both modes)
//  underflow  out  1       sticky: pop attempted while empty
// BEHAVIOUR
//  - Storage: DEPTH x DATA_W register array, circular; wp = next write index (mod DEPTH), count.
//  - Reset (async, rst=1): wp=0, count=0, overflow=0, underflow=0; array not reset; top/peek_data=0.
//  - top, peek_data, count, empty, full are combinational from registered state: they reflect an
//    operation in the cycle after the edge that performed it (zero extra latency).
//  - Per rising edge, priority: flush > (push,pop) decode. clear_err is independent.
//  - flush: wp=0, count=0; flags unchanged unless clear_err also high.
//  - push only, not full: mem[wp]<=push_data; wp<=wp+1 mod DEPTH; count+1.
//  - push only, full, WRAP_ON_FULL=0: no state change; overflow<=1.
//  - push only, full, WRAP_ON_FULL=1: mem[wp]<=push_data; wp advances; count stays DEPTH (oldest lost);
//    overflow<=1.
//  - pop only, not empty: wp<=wp-1 mod DEPTH; count-1. Popped data was visible on top before the edge.
//  - pop only, empty: no state change; underflow<=1.
//  - push+pop, not empty: replace top: mem[wp-1]<=push_data; wp, count unchanged; no flag.
//  - push+pop, empty: executes as push only; underflow<=1.
//  - Flags: set has priority over clear_err in the same cycle.
//  - Wrap arithmetic: decrement of wp=0 gives DEPTH-1; increment of DEPTH-1 gives 0 (explicit compare,
//    not bit truncation, since DEPTH need not be 2^n).
//  - peek: index = (wp-1-peek_idx) mod DEPTH, valid only when peek_idx < count.
//  - rst asserted mid-operation discards any pending push/pop; no partial write.
// STRUCTURE
//  - Shared header/package call_stack_pkg: op encoding (OP_NONE, OP_PUSH, OP_POP, OP_REPL) and the
//    default DATA_W/DEPTH constants used by the core top level.
//  - One sub-module stack_ptr_wrap: modulo-DEPTH increment/decrement/offset of an AW-bit index.
//  - Top-level processor instantiates call_stack with DATA_W=32, DEPTH=16, WRAP_ON_FULL=0.
// TESTING
//  1. Reset then push 0x10,0x20,0x30 -> top=0x30, count=3, peek_idx=2 -> 0x10; pop x3 -> empty, top=0.
//  2. DEPTH=4, WRAP=0: push 1..5 -> count=4, full=1, top=4, overflow=1; clear_err -> overflow=0.
//  3. DEPTH=4, WRAP=1: push 1..6 -> count=4, top=6, peek_idx=3 -> 3, overflow=1; pop x4 -> 6,5,4,3.
//  4. Empty: pop -> underflow=1, count=0; push+pop with 0xAB -> count=1, top=0xAB, underflow=1.
//  5. count=2 top=0x22: push+pop 0x99 -> count=2, top=0x99, peek_idx=1 unchanged; flush -> count=0.
//  6. DEPTH=5 (non-2^n): push 7 values WRAP=1, pop 5 -> correct LIFO order; rst mid-burst -> count=0.

Source files
------------

// File: rtl/call_stack_pkg.sv
// Shared definitions for the return-address/data stack: operation encoding and default sizing.
package call_stack_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_DEPTH  = 16;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_REPL = 2'b11
    } op_e;

    function automatic op_e decode_op(input logic push, input logic pop);
        op_e op;
        case ({push, pop})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = OP_REPL;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/stack_ptr_wrap.sv
// Modulo-DEPTH index arithmetic: increment, decrement and "top minus offset" of an AW-bit pointer.
// Wrap is done by explicit compare so DEPTH need not be a power of two.
module stack_ptr_wrap #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic [AW-1:0] i_idx,
    input  logic [AW-1:0] i_off,
    output logic [AW-1:0] o_inc,
    output logic [AW-1:0] o_dec,
    output logic [AW-1:0] o_below
);

    localparam int unsigned SW = AW + 1;

    logic [SW-1:0] w_sum;

    always_comb begin
        o_inc = (i_idx == AW'(DEPTH - 1)) ? '0 : i_idx + AW'(1);
        o_dec = (i_idx == '0) ? AW'(DEPTH - 1) : i_idx - AW'(1);
    end

    // idx - 1 - off (mod DEPTH); offsets beyond DEPTH map to 0 to keep the index in range
    always_comb begin
        w_sum   = SW'(i_idx) + SW'(DEPTH - 1) - SW'(i_off);
        o_below = '0;
        if ({1'b0, i_off} < SW'(DEPTH)) begin
            if (w_sum >= SW'(DEPTH)) begin
                o_below = AW'(w_sum - SW'(DEPTH));
            end else begin
                o_below = AW'(w_sum);
            end
        end
    end

endmodule

// File: rtl/call_stack.sv
// Parametrised circular return-address/data stack with replace, peek, flush and sticky error flags.
module call_stack
    import call_stack_pkg::*;
#(
    parameter  int unsigned DATA_W       = DEF_DATA_W,
    parameter  int unsigned DEPTH        = DEF_DEPTH,
    parameter  bit          WRAP_ON_FULL = 1'b0,
    localparam int unsigned AW           = $clog2(DEPTH),
    localparam int unsigned CW           = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    input  logic              flush,
    input  logic              clear_err,
    input  logic [AW-1:0]     peek_idx,
    output logic [DATA_W-1:0] top,
    output logic [DATA_W-1:0] peek_data,
    output logic [CW-1:0]     count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wp;
    logic [CW-1:0]     r_count;
    logic              r_ovf;
    logic              r_unf;

    logic [AW-1:0]     w_wp_inc;
    logic [AW-1:0]     w_wp_dec;
    logic [AW-1:0]     w_peek_addr;
    logic [AW-1:0]     w_wp_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [AW-1:0]     w_waddr;
    logic              w_we;
    logic              w_ovf_set;
    logic              w_unf_set;
    logic              w_empty;
    logic              w_full;
    op_e               w_op;

    stack_ptr_wrap #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ptr (
        .i_idx   (r_wp),
        .i_off   (peek_idx),
        .o_inc   (w_wp_inc),
        .o_dec   (w_wp_dec),
        .o_below (w_peek_addr)
    );

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_op    = decode_op(push, pop);

    // Next pointer/count, write enable and flag-set decode; flush overrides everything
    always_comb begin
        w_wp_nxt  = r_wp;
        w_cnt_nxt = r_count;
        w_waddr   = r_wp;
        w_we      = 1'b0;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        if (flush) begin
            w_wp_nxt  = '0;
            w_cnt_nxt = '0;
        end else begin
            case (w_op)
                OP_PUSH: begin
                    if (!w_full) begin
                        w_we      = 1'b1;
                        w_wp_nxt  = w_wp_inc;
                        w_cnt_nxt = r_count + CW'(1);
                    end else begin
                        w_ovf_set = 1'b1;
                        if (WRAP_ON_FULL) begin
                            w_we     = 1'b1;
                            w_wp_nxt = w_wp_inc;
                        end
                    end
                end
                OP_POP: begin
                    if (!w_empty) begin
                        w_wp_nxt  = w_wp_dec;
                        w_cnt_nxt = r_count - CW'(1);
                    end else begin
                        w_unf_set = 1'b1;
                    end
                end
                OP_REPL: begin
                    w_we = 1'b1;
                    if (w_empty) begin
                        w_wp_nxt  = w_wp_inc;
                        w_cnt_nxt = r_count + CW'(1);
                        w_unf_set = 1'b1;
                    end else begin
                        w_waddr = w_wp_dec;
                    end
                end
                default: begin
                    w_we = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_wp    <= w_wp_nxt;
            r_count <= w_cnt_nxt;
            r_ovf   <= w_ovf_set | (r_ovf & ~clear_err);
            r_unf   <= w_unf_set | (r_unf & ~clear_err);
        end
    end

    // Storage is not reset; a write coinciding with reset is dropped
    always_ff @(posedge clk) begin
        if (w_we && !rst) begin
            r_mem[w_waddr] <= push_data;
        end
    end

    always_comb begin
        top       = w_empty ? '0 : r_mem[w_wp_dec];
        peek_data = (CW'(peek_idx) < r_count) ? r_mem[w_peek_addr] : '0;
    end

    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule
